uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, 16x-free mid-bit sampling) feeding a first-word
// fall-through byte FIFO with sticky framing and overrun flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_rxd,
    input  logic              rd_en,
    input  logic              err_clr,
    output logic [7:0]        dout,
    output logic              rxd_rdy,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              frame_err,
    output logic              overrun
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, WAIT_IDLE
    } state_t;

    state_t              state;
    logic                rx_meta;
    logic                rxs;
    logic [CW-1:0]       cyc;
    logic [2:0]          bitc;
    logic [7:0]          shreg;
    logic                at_end;
    logic                push;
    logic                fe_set;
    logic                pop;
    logic                wr;
    logic                ov_set;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [7:0]          mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= ser_rxd;
            rxs     <= rx_meta;
        end
    end

    always_comb begin
        at_end = (cyc == BIT_END);
        push   = (state == STOP) && at_end && rxs;
        fe_set = (state == STOP) && at_end && !rxs;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cyc   <= '0;
            bitc  <= '0;
            shreg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cyc  <= '0;
                    bitc <= '0;
                    if (!rxs) state <= START;
                end
                START: begin
                    if (cyc == HALF) begin
                        cyc   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (at_end) begin
                        cyc   <= '0;
                        shreg <= {rxs, shreg[7:1]};
                        bitc  <= bitc + 1'b1;
                        if (bitc == 3'd7) state <= STOP;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                STOP: begin
                    if (at_end) begin
                        cyc   <= '0;
                        state <= rxs ? IDLE : WAIT_IDLE;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A pop frees the slot on the same edge, so push-on-full still lands.
    assign pop    = rd_en && rxd_rdy;
    assign wr     = push && (!full || pop);
    assign ov_set = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr && !pop)      count <= count + 1'b1;
            else if (pop && !wr) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (fe_set)       frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (ov_set)       overrun <= 1'b1;
            else if (err_clr) overrun <= 1'b0;
        end
    end

    assign rxd_rdy = (count != '0);
    assign full    = (count == FULL_CNT);
    assign dout    = rxd_rdy ? mem[rd_ptr] : 8'h00;

endmodule
